hd44780_writer: RTL and testbench

- Character sink for the processor's LCD handshake (`ascii`/`ready`/`consume`).
- Drives an HD44780-compatible 16x2 panel on LCD_DATA/LCD_RS/LCD_E/LCD_RW in 8-bit, write-only mode, with fixed timed delays.
- Runs the power-on init sequence, tracks the cursor position and wraps lines.
- Accepts one byte per handshake.

---
 rtl/hd44780_writer_pkg.sv | 52 +++++
 rtl/hd44780_writer_if.sv | 9 +
 rtl/hd44780_writer_lcd_bus_cycle.sv | 93 +++++++++
 rtl/hd44780_writer.sv | 188 ++++++++++++++++++
 tb/tb_hd44780_writer.sv | 394 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hd44780_writer_pkg.sv
// Shared constants, state types and helpers for the HD44780 character writer.
// Control-character handling is enabled with the LCD_CTRL_CHARS_EN macro.
package hd44780_writer_pkg;

    localparam logic [7:0] LCD_FUNC_SET = 8'h38;
    localparam logic [7:0] LCD_DISP_ON  = 8'h0C;
    localparam logic [7:0] LCD_CLEAR    = 8'h01;
    localparam logic [7:0] LCD_ENTRY    = 8'h06;
    localparam logic [7:0] LCD_DDRAM    = 8'h80;
    localparam logic [7:0] LCD_LINE2    = 8'h40;

    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_FF = 8'h0C;
    localparam logic [7:0] ASCII_BS = 8'h08;

    localparam logic [2:0] INIT_LAST = 3'd5;

    typedef enum logic [3:0] {
        PWR_WAIT,
        INIT_GO,
        INIT_WAIT,
        IDLE,
        DATA_GO,
        DATA_WAIT,
        ADDR_GO,
        CLEAR_GO,
        CMD_WAIT,
        RELEASE
    } writer_state_e;

    typedef enum logic [1:0] {
        BC_IDLE,
        BC_SETUP,
        BC_PULSE,
        BC_WAIT
    } bus_state_e;

    // Power-on command ROM: three function sets, display on, clear, entry mode.
    function automatic logic [7:0] init_cmd(input logic [2:0] idx);
        case (idx)
            3'd0, 3'd1, 3'd2: return LCD_FUNC_SET;
            3'd3:             return LCD_DISP_ON;
            3'd4:             return LCD_CLEAR;
            default:          return LCD_ENTRY;
        endcase
    endfunction

    function automatic logic [7:0] ddram_addr(input logic row, input logic [7:0] col);
        return LCD_DDRAM | (row ? LCD_LINE2 : 8'h00) | col;
    endfunction

endpackage

// File: rtl/hd44780_writer_if.sv
// Processor-side byte handshake: the processor drives ascii/consume, the writer drives ready.
interface hd44780_writer_if;
    logic [7:0] ascii;
    logic       consume;
    logic       ready;

    modport master (output ascii, output consume, input ready);
    modport slave  (input ascii, input consume, output ready);
endinterface

// File: rtl/hd44780_writer_lcd_bus_cycle.sv
// One HD44780 bus write: RS/DATA setup, timed E pulse, then a post-write busy wait.
module lcd_bus_cycle
    import hd44780_writer_pkg::*;
#(
    parameter int unsigned T_SETUP  = 2,
    parameter int unsigned T_EPULSE = 25
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        rs,
    input  logic [7:0]  data_in,
    input  logic [31:0] wait_cycles,
    output logic        done,
    output logic        lcd_e,
    output logic        lcd_rs,
    output logic [7:0]  lcd_data
);

    bus_state_e  state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] wait_q, wait_d;
    logic        rs_q, rs_d;
    logic [7:0]  data_q, data_d;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= BC_IDLE;
            cnt_q   <= '0;
            wait_q  <= '0;
            rs_q    <= 1'b0;
            data_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wait_q  <= wait_d;
            rs_q    <= rs_d;
            data_q  <= data_d;
        end
    end

    // RS/DATA stay latched after the post-wait so the bus never changes under E.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wait_d  = wait_q;
        rs_d    = rs_q;
        data_d  = data_q;
        done    = 1'b0;
        case (state_q)
            BC_IDLE: begin
                if (start) begin
                    rs_d    = rs;
                    data_d  = data_in;
                    wait_d  = wait_cycles;
                    cnt_d   = '0;
                    state_d = BC_SETUP;
                end
            end
            BC_SETUP: begin
                if (cnt_q + 32'd1 >= T_SETUP) begin
                    cnt_d   = '0;
                    state_d = BC_PULSE;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            BC_PULSE: begin
                if (cnt_q + 32'd1 >= T_EPULSE) begin
                    cnt_d   = '0;
                    state_d = BC_WAIT;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            BC_WAIT: begin
                if (cnt_q + 32'd1 >= wait_q) begin
                    done    = 1'b1;
                    cnt_d   = '0;
                    state_d = BC_IDLE;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            default: state_d = BC_IDLE;
        endcase
    end

    assign lcd_e    = (state_q == BC_PULSE);
    assign lcd_rs   = rs_q;
    assign lcd_data = data_q;

endmodule

// File: rtl/hd44780_writer.sv
// HD44780 16x2 character writer: power-on init, cursor tracking with line wrap, byte handshake.
// Optional control-character handling (LF, FF, BS) is enabled by defining LCD_CTRL_CHARS_EN.
module hd44780_writer
    import hd44780_writer_pkg::*;
#(
    parameter int unsigned T_POWERUP = 750000,
    parameter int unsigned T_INIT1   = 205000,
    parameter int unsigned T_INIT2   = 5000,
    parameter int unsigned T_CMD     = 2000,
    parameter int unsigned T_CLEAR   = 82000,
    parameter int unsigned T_SETUP   = 2,
    parameter int unsigned T_EPULSE  = 25,
    parameter int unsigned COLS      = 16
) (
    input  logic              clock,
    input  logic              reset,
    hd44780_writer_if.slave   host,
    output logic [7:0]        lcd_data,
    output logic              lcd_rs,
    output logic              lcd_e,
    output logic              lcd_rw
);

    writer_state_e state_q, state_d;
    logic [31:0]   cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    char_q, char_d;
    logic [7:0]    col_q, col_d;
    logic          row_q, row_d;

    logic          bus_start;
    logic          bus_rs;
    logic [7:0]    bus_byte;
    logic [31:0]   bus_wait;
    logic          bus_done;

    function automatic logic [31:0] init_wait(input logic [2:0] idx);
        case (idx)
            3'd0:    return T_INIT1;
            3'd1:    return T_INIT2;
            3'd4:    return T_CLEAR;
            default: return T_CMD;
        endcase
    endfunction

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= PWR_WAIT;
            cnt_q   <= '0;
            idx_q   <= 3'd0;
            char_q  <= 8'h00;
            col_q   <= 8'h00;
            row_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            char_q  <= char_d;
            col_q   <= col_d;
            row_q   <= row_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        char_d    = char_q;
        col_d     = col_q;
        row_d     = row_q;
        bus_start = 1'b0;
        bus_rs    = 1'b0;
        bus_byte  = 8'h00;
        bus_wait  = T_CMD;
        case (state_q)
            PWR_WAIT: begin
                if (cnt_q + 32'd1 >= T_POWERUP) begin
                    cnt_d   = '0;
                    state_d = INIT_GO;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            INIT_GO: begin
                bus_start = 1'b1;
                bus_byte  = init_cmd(idx_q);
                bus_wait  = init_wait(idx_q);
                state_d   = INIT_WAIT;
            end
            INIT_WAIT: begin
                if (bus_done) begin
                    if (idx_q == INIT_LAST) begin
                        state_d = IDLE;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = INIT_GO;
                    end
                end
            end
            IDLE: begin
                if (host.consume) begin
                    char_d = host.ascii;
`ifdef LCD_CTRL_CHARS_EN
                    // Cursor moves are applied here so ADDR_GO sees the new position.
                    if (host.ascii >= 8'h20) begin
                        state_d = DATA_GO;
                    end else if (host.ascii == ASCII_LF) begin
                        col_d   = 8'h00;
                        row_d   = ~row_q;
                        state_d = ADDR_GO;
                    end else if (host.ascii == ASCII_FF) begin
                        col_d   = 8'h00;
                        row_d   = 1'b0;
                        state_d = CLEAR_GO;
                    end else if (host.ascii == ASCII_BS && col_q != 8'h00) begin
                        col_d   = col_q - 8'd1;
                        state_d = ADDR_GO;
                    end else begin
                        state_d = RELEASE;
                    end
`else
                    state_d = DATA_GO;
`endif
                end
            end
            DATA_GO: begin
                bus_start = 1'b1;
                bus_rs    = 1'b1;
                bus_byte  = char_q;
                state_d   = DATA_WAIT;
            end
            DATA_WAIT: begin
                if (bus_done) begin
                    if (col_q + 8'd1 == 8'(COLS)) begin
                        col_d   = 8'h00;
                        row_d   = ~row_q;
                        state_d = ADDR_GO;
                    end else begin
                        col_d   = col_q + 8'd1;
                        state_d = host.consume ? RELEASE : IDLE;
                    end
                end
            end
            ADDR_GO: begin
                bus_start = 1'b1;
                bus_byte  = ddram_addr(row_q, col_q);
                state_d   = CMD_WAIT;
            end
            CLEAR_GO: begin
                bus_start = 1'b1;
                bus_byte  = LCD_CLEAR;
                bus_wait  = T_CLEAR;
                state_d   = CMD_WAIT;
            end
            CMD_WAIT: begin
                if (bus_done) begin
                    state_d = host.consume ? RELEASE : IDLE;
                end
            end
            RELEASE: begin
                if (!host.consume) begin
                    state_d = IDLE;
                end
            end
            default: state_d = PWR_WAIT;
        endcase
    end

    assign host.ready = (state_q == IDLE);
    assign lcd_rw     = 1'b0;

    lcd_bus_cycle #(
        .T_SETUP  (T_SETUP),
        .T_EPULSE (T_EPULSE)
    ) u_bus (
        .clock       (clock),
        .reset       (reset),
        .start       (bus_start),
        .rs          (bus_rs),
        .data_in     (bus_byte),
        .wait_cycles (bus_wait),
        .done        (bus_done),
        .lcd_e       (lcd_e),
        .lcd_rs      (lcd_rs),
        .lcd_data    (lcd_data)
    );

endmodule

// File: tb/tb_hd44780_writer.sv
// Scoreboard bench for hd44780_writer: expected E pulses queued at stimulus, matched against observed pulses.
module tb_hd44780_writer;

    localparam int T_PU  = 10;
    localparam int T_I1  = 4;
    localparam int T_I2  = 4;
    localparam int T_C   = 4;
    localparam int T_CL  = 20;
    localparam int T_S   = 2;
    localparam int T_E   = 3;
    localparam int NCOLS = 16;
    localparam int INIT_MIN = T_PU + 6 * (T_S + T_E) + T_I1 + T_I2 + 3 * T_C + T_CL;
    localparam int DATA_MIN = 1 + T_S + T_E + T_C;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] lcd_data;
    logic       lcd_rs;
    logic       lcd_e;
    logic       lcd_rw;

    hd44780_writer_if host();

    hd44780_writer #(
        .T_POWERUP (T_PU),
        .T_INIT1   (T_I1),
        .T_INIT2   (T_I2),
        .T_CMD     (T_C),
        .T_CLEAR   (T_CL),
        .T_SETUP   (T_S),
        .T_EPULSE  (T_E),
        .COLS      (NCOLS)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .host     (host),
        .lcd_data (lcd_data),
        .lcd_rs   (lcd_rs),
        .lcd_e    (lcd_e),
        .lcd_rw   (lcd_rw)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    logic [8:0] exp_q[$];
    logic [8:0] obs_q[$];
    int         len_q[$];
    int         model_col = 0;
    logic       model_row = 1'b0;

    // Pulse monitor: records {rs,data} at E rise and the pulse width when E falls.
    logic       prev_e = 1'b0;
    int         cur_len = 0;
    logic [8:0] cur_pulse = 9'h000;
    always @(negedge clock) begin
        if (lcd_e && !prev_e) begin
            cur_pulse = {lcd_rs, lcd_data};
            cur_len   = 1;
        end else if (lcd_e) begin
            cur_len++;
        end else if (prev_e) begin
            obs_q.push_back(cur_pulse);
            len_q.push_back(cur_len);
        end
        prev_e = lcd_e;
    end

    function automatic void push_init();
        exp_q.push_back({1'b0, 8'h38});
        exp_q.push_back({1'b0, 8'h38});
        exp_q.push_back({1'b0, 8'h38});
        exp_q.push_back({1'b0, 8'h0C});
        exp_q.push_back({1'b0, 8'h01});
        exp_q.push_back({1'b0, 8'h06});
    endfunction

    // Reference model of the cursor and the bus writes each byte should cause.
    function automatic void model_byte(input logic [7:0] b);
`ifdef LCD_CTRL_CHARS_EN
        if (b < 8'h20) begin
            if (b == 8'h0A) begin
                model_col = 0;
                model_row = !model_row;
                exp_q.push_back({1'b0, model_row ? 8'hC0 : 8'h80});
            end else if (b == 8'h0C) begin
                exp_q.push_back({1'b0, 8'h01});
                model_col = 0;
                model_row = 1'b0;
            end else if (b == 8'h08 && model_col > 0) begin
                model_col--;
                exp_q.push_back({1'b0, (model_row ? 8'hC0 : 8'h80) | 8'(model_col)});
            end
            return;
        end
`endif
        exp_q.push_back({1'b1, b});
        model_col++;
        if (model_col == NCOLS) begin
            model_col = 0;
            model_row = !model_row;
            exp_q.push_back({1'b0, model_row ? 8'hC0 : 8'h80});
        end
    endfunction

    task automatic send_byte(input logic [7:0] b, output int lat);
        int n;
        n = 0;
        while (!host.ready && n < 500) begin
            @(negedge clock);
            n++;
        end
        n_checks++;
        if (!host.ready) begin
            n_fail++;
            $display("[TB] FAIL send_idle: ready=%b, required 1 before sending %h", host.ready, b);
        end
        host.ascii   = b;
        host.consume = 1'b1;
        model_byte(b);
        @(negedge clock);
        lat = 1;
        n_checks++;
        if (host.ready !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL ready_fall: ready=%b one cycle after consume, required 0", host.ready);
        end
        host.consume = 1'b0;
        host.ascii   = 8'($urandom);
        while (!host.ready && lat < 500) begin
            @(negedge clock);
            lat++;
        end
        n_checks++;
        if (!host.ready) begin
            n_fail++;
            $display("[TB] FAIL ready_return: ready=%b after %0d cycles, required 1", host.ready, lat);
        end
    endtask

    task automatic test_reset();
        int lat;
        logic early;
        logic [8:0] exp_v, obs_v;
        int len_v;
        host.ascii   = 8'h00;
        host.consume = 1'b0;
        reset = 1'b1;
        #1 reset = 1'b0;
        repeat (3) @(negedge clock);
        n_checks += 5;
        if (host.ready !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_ready: got %b, required 0", host.ready); end
        if (lcd_e !== 1'b0)      begin n_fail++; $display("[TB] FAIL reset_e: got %b, required 0", lcd_e); end
        if (lcd_rs !== 1'b0)     begin n_fail++; $display("[TB] FAIL reset_rs: got %b, required 0", lcd_rs); end
        if (lcd_data !== 8'h00)  begin n_fail++; $display("[TB] FAIL reset_data: got %h, required 00", lcd_data); end
        if (lcd_rw !== 1'b0)     begin n_fail++; $display("[TB] FAIL reset_rw: got %b, required 0", lcd_rw); end
        push_init();
        host.consume = 1'b1;
        host.ascii   = 8'h55;
        reset = 1'b1;
        lat   = 0;
        early = 1'b0;
        while (!host.ready && lat < 1000) begin
            @(negedge clock);
            lat++;
            if (lat == 20) host.consume = 1'b0;
            if (host.ready && lat < INIT_MIN) early = 1'b1;
        end
        n_checks += 2;
        if (early || lat < INIT_MIN || lat > INIT_MIN + 20) begin
            n_fail++;
            $display("[TB] FAIL init_latency: ready rose after %0d cycles, required %0d..%0d", lat, INIT_MIN, INIT_MIN + 20);
        end
        if (obs_q.size() != 6) begin
            n_fail++;
            $display("[TB] FAIL init_pulse_count: got %0d pulses at ready, required 6", obs_q.size());
        end
        while (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) begin
                n_fail++;
                $display("[TB] FAIL init_pulse: got none, required rs/data %h", exp_v);
            end else begin
                obs_v = obs_q.pop_front();
                len_v = len_q.pop_front();
                if (obs_v !== exp_v) begin n_fail++; $display("[TB] FAIL init_pulse: got rs/data %h, required %h", obs_v, exp_v); end
                n_checks++;
                if (len_v != T_E) begin n_fail++; $display("[TB] FAIL init_e_width: got %0d, required %0d", len_v, T_E); end
            end
        end
        n_checks++;
        if (obs_q.size() != 0) begin n_fail++; $display("[TB] FAIL init_extra: %0d extra pulses, required 0", obs_q.size()); end
    endtask

    task automatic test_single_char();
        int lat;
        logic [8:0] exp_v, obs_v;
        int len_v;
        send_byte(8'h41, lat);
        n_checks++;
        if (lat < DATA_MIN || lat > DATA_MIN + 5) begin
            n_fail++;
            $display("[TB] FAIL char_latency: got %0d cycles, required %0d..%0d", lat, DATA_MIN, DATA_MIN + 5);
        end
        while (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) begin
                n_fail++;
                $display("[TB] FAIL char_pulse: got none, required rs/data %h", exp_v);
            end else begin
                obs_v = obs_q.pop_front();
                len_v = len_q.pop_front();
                if (obs_v !== exp_v) begin n_fail++; $display("[TB] FAIL char_pulse: got rs/data %h, required %h", obs_v, exp_v); end
                n_checks++;
                if (len_v != T_E) begin n_fail++; $display("[TB] FAIL char_e_width: got %0d, required %0d", len_v, T_E); end
            end
        end
        n_checks++;
        if (obs_q.size() != 0) begin n_fail++; $display("[TB] FAIL char_extra: %0d extra pulses, required 0", obs_q.size()); end
    endtask

    task automatic test_hold_consume();
        int n;
        logic ready_seen;
        logic [8:0] exp_v, obs_v;
        int len_v;
        host.ascii   = 8'h5A;
        host.consume = 1'b1;
        model_byte(8'h5A);
        @(negedge clock);
        n_checks++;
        if (host.ready !== 1'b0) begin n_fail++; $display("[TB] FAIL hold_ready_fall: got %b, required 0", host.ready); end
        n = 0;
        while (obs_q.size() == 0 && n < 100) begin
            @(negedge clock);
            n++;
        end
        n_checks++;
        if (obs_q.size() == 0) begin n_fail++; $display("[TB] FAIL hold_pulse_timeout: no pulse after %0d cycles, required 1", n); end
        ready_seen = 1'b0;
        repeat (20 + T_C) begin
            @(negedge clock);
            if (host.ready) ready_seen = 1'b1;
        end
        n_checks += 2;
        if (ready_seen) begin n_fail++; $display("[TB] FAIL hold_ready: ready rose while consume high, required 0"); end
        if (obs_q.size() != 1) begin n_fail++; $display("[TB] FAIL hold_pulse_count: got %0d, required 1", obs_q.size()); end
        host.consume = 1'b0;
        @(negedge clock);
        n_checks++;
        if (host.ready !== 1'b1) begin n_fail++; $display("[TB] FAIL hold_ready_rise: got %b after consume fell, required 1", host.ready); end
        while (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) begin
                n_fail++;
                $display("[TB] FAIL hold_pulse: got none, required rs/data %h", exp_v);
            end else begin
                obs_v = obs_q.pop_front();
                len_v = len_q.pop_front();
                if (obs_v !== exp_v) begin n_fail++; $display("[TB] FAIL hold_pulse: got rs/data %h, required %h", obs_v, exp_v); end
            end
        end
    endtask

    task automatic test_line_wrap();
        int lat;
        logic [8:0] exp_v, obs_v;
        int len_v;
        for (int i = 0; i < 32; i++) begin
            send_byte(8'h50 + 8'(i), lat);
        end
        while (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) begin
                n_fail++;
                $display("[TB] FAIL wrap_pulse: got none, required rs/data %h", exp_v);
            end else begin
                obs_v = obs_q.pop_front();
                len_v = len_q.pop_front();
                if (obs_v !== exp_v) begin n_fail++; $display("[TB] FAIL wrap_pulse: got rs/data %h, required %h", obs_v, exp_v); end
            end
        end
        n_checks++;
        if (obs_q.size() != 0) begin n_fail++; $display("[TB] FAIL wrap_extra: %0d extra pulses, required 0", obs_q.size()); end
    endtask

    task automatic test_ctrl_chars();
        int lat, ff_lat;
        logic [8:0] exp_v, obs_v;
        int len_v;
        send_byte(8'h42, lat);
        send_byte(8'h0C, ff_lat);
        send_byte(8'h43, lat);
        n_checks++;
`ifdef LCD_CTRL_CHARS_EN
        if (ff_lat < 1 + T_S + T_E + T_CL || ff_lat > 1 + T_S + T_E + T_CL + 5) begin
            n_fail++;
            $display("[TB] FAIL clear_latency: got %0d cycles, required %0d..%0d", ff_lat, 1 + T_S + T_E + T_CL, 1 + T_S + T_E + T_CL + 5);
        end
`else
        if (ff_lat < DATA_MIN || ff_lat > DATA_MIN + 5) begin
            n_fail++;
            $display("[TB] FAIL ff_data_latency: got %0d cycles, required %0d..%0d", ff_lat, DATA_MIN, DATA_MIN + 5);
        end
`endif
        while (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) begin
                n_fail++;
                $display("[TB] FAIL ctrl_pulse: got none, required rs/data %h", exp_v);
            end else begin
                obs_v = obs_q.pop_front();
                len_v = len_q.pop_front();
                if (obs_v !== exp_v) begin n_fail++; $display("[TB] FAIL ctrl_pulse: got rs/data %h, required %h", obs_v, exp_v); end
            end
        end
        n_checks++;
        if (obs_q.size() != 0) begin n_fail++; $display("[TB] FAIL ctrl_extra: %0d extra pulses, required 0", obs_q.size()); end
    endtask

    task automatic test_reset_mid_pulse();
        int n, lat;
        logic [8:0] exp_v, obs_v;
        int len_v;
        host.ascii   = 8'h44;
        host.consume = 1'b1;
        n = 0;
        while (!lcd_e && n < 100) begin
            @(negedge clock);
            n++;
        end
        n_checks++;
        if (!lcd_e) begin n_fail++; $display("[TB] FAIL mid_pulse_timeout: lcd_e=%b after %0d cycles, required 1", lcd_e, n); end
        #2 reset = 1'b0;
        #1;
        n_checks += 2;
        if (lcd_e !== 1'b0)      begin n_fail++; $display("[TB] FAIL abort_e: got %b, required 0", lcd_e); end
        if (host.ready !== 1'b0) begin n_fail++; $display("[TB] FAIL abort_ready: got %b, required 0", host.ready); end
        host.consume = 1'b0;
        repeat (3) @(negedge clock);
        exp_q.delete();
        obs_q.delete();
        len_q.delete();
        model_col = 0;
        model_row = 1'b0;
        push_init();
        reset = 1'b1;
        lat = 0;
        while (!host.ready && lat < 1000) begin
            @(negedge clock);
            lat++;
        end
        n_checks++;
        if (lat < INIT_MIN || lat > INIT_MIN + 20) begin
            n_fail++;
            $display("[TB] FAIL reinit_latency: ready rose after %0d cycles, required %0d..%0d", lat, INIT_MIN, INIT_MIN + 20);
        end
        send_byte(8'h45, lat);
        while (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) begin
                n_fail++;
                $display("[TB] FAIL reinit_pulse: got none, required rs/data %h", exp_v);
            end else begin
                obs_v = obs_q.pop_front();
                len_v = len_q.pop_front();
                if (obs_v !== exp_v) begin n_fail++; $display("[TB] FAIL reinit_pulse: got rs/data %h, required %h", obs_v, exp_v); end
            end
        end
        n_checks++;
        if (obs_q.size() != 0) begin n_fail++; $display("[TB] FAIL reinit_extra: %0d extra pulses, required 0", obs_q.size()); end
    endtask

    initial begin
        $display("[TB] hd44780_writer bench start");
        test_reset();
        test_single_char();
        test_hold_consume();
        test_line_wrap();
        test_ctrl_chars();
        test_reset_mid_pulse();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
